// File: rtl/rvtu_arb_sram_target.sv
// RVTU pair-arb cacheline responder: serialized 32-bit beat protocol in front of a
// 1-cycle-latency 128-bit SRAM macro, with a sticky out-of-window error flag.
module rvtu_arb_sram_target #(
    parameter int          DEPTH   = 256,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int          ACK_DLY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dfp_read,
    input  logic                     dfp_write,
    output logic                     dfp_ack,
    input  logic [31:0]              dfp_wdata,
    output logic [31:0]              dfp_rdata,
    output logic                     dfp_rdata_valid,
    output logic                     sram_re,
    output logic                     sram_we,
    output logic [$clog2(DEPTH)-1:0] sram_idx,
    output logic [127:0]             sram_wdata,
    input  logic [127:0]             sram_rdata,
    output logic                     err_oob
);

    localparam int          IW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 4;

    typedef enum logic [2:0] {
        IDLE, WAIT, ADDR, WBEAT, WCOMMIT, RSRAM, RHDR, RBEAT
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [1:0]      beat_q, beat_d;
    logic            is_rd_q, is_rd_d;
    logic            oob_q, oob_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [127:0]    line_q, line_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            re_q, re_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic            ack;

    logic            req;
    logic [31:0]     off;
    logic            oob_now;

    assign req     = dfp_read | dfp_write;
    assign off     = dfp_wdata - BASE;
    // Offset compared in 33 bits so a window ending at 2^32 cannot wrap.
    assign oob_now = (dfp_wdata < BASE) || ({1'b0, off} >= SPAN);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        beat_d   = beat_q;
        is_rd_d  = is_rd_q;
        oob_d    = oob_q;
        idx_d    = idx_q;
        line_d   = line_q;
        rdata_d  = '0;
        rvalid_d = 1'b0;
        re_d     = 1'b0;
        we_d     = 1'b0;
        err_d    = err_q;
        ack      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    // Ack is Mealy so a zero-delay target accepts in the request cycle.
                    if (ACK_DLY == 0) begin
                        ack     = 1'b1;
                        is_rd_d = dfp_read;
                        state_d = ADDR;
                    end else begin
                        wcnt_d  = 4'd1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (wcnt_q == 4'(ACK_DLY)) begin
                    ack     = 1'b1;
                    is_rd_d = dfp_read;
                    state_d = ADDR;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            ADDR: begin
                oob_d  = oob_now;
                idx_d  = IW'(off >> 4);
                beat_d = 2'd0;
                if (oob_now) err_d = 1'b1;
                if (is_rd_q) begin
                    re_d    = !oob_now;
                    state_d = RSRAM;
                end else begin
                    state_d = WBEAT;
                end
            end
            WBEAT: begin
                line_d[32*beat_q +: 32] = dfp_wdata;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    we_d    = !oob_q;
                    state_d = WCOMMIT;
                end
            end
            WCOMMIT: state_d = IDLE;
            RSRAM: begin
                rvalid_d = 1'b1;
                state_d  = RHDR;
            end
            RHDR: begin
                line_d   = oob_q ? '0 : sram_rdata;
                rdata_d  = oob_q ? '0 : sram_rdata[31:0];
                rvalid_d = 1'b1;
                beat_d   = 2'd0;
                state_d  = RBEAT;
            end
            RBEAT: begin
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = line_q[32*(int'(beat_q) + 1) +: 32];
                    beat_d   = beat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            beat_q   <= '0;
            is_rd_q  <= 1'b0;
            oob_q    <= 1'b0;
            idx_q    <= '0;
            line_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            beat_q   <= beat_d;
            is_rd_q  <= is_rd_d;
            oob_q    <= oob_d;
            idx_q    <= idx_d;
            line_q   <= line_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            re_q     <= re_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign dfp_ack         = ack;
    assign dfp_rdata       = rdata_q;
    assign dfp_rdata_valid = rvalid_q;
    assign sram_re         = re_q;
    assign sram_we         = we_q;
    assign sram_idx        = idx_q;
    assign sram_wdata      = line_q;
    assign err_oob         = err_q;

endmodule

// File: tb/tb_rvtu_arb_sram_target.sv
// Bench for rvtu_arb_sram_target: two targets (zero-delay and delayed/offset window)
// checked every cycle against a transaction-level timeline model.
module tb_rvtu_arb_sram_target;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rd0, wr0, ack0, rv0, re0, we0, err0;
    logic [31:0]  wd0, rdat0;
    logic [7:0]   idx0;
    logic [127:0] swd0, srd0;
    logic         rd1, wr1, ack1, rv1, re1, we1, err1;
    logic [31:0]  wd1, rdat1;
    logic [3:0]   idx1;
    logic [127:0] swd1, srd1;

    rvtu_arb_sram_target #(.DEPTH(256), .BASE(32'h0), .ACK_DLY(0)) u_dut0 (
        .clk(clk), .rst(rst), .dfp_read(rd0), .dfp_write(wr0), .dfp_ack(ack0),
        .dfp_wdata(wd0), .dfp_rdata(rdat0), .dfp_rdata_valid(rv0), .sram_re(re0),
        .sram_we(we0), .sram_idx(idx0), .sram_wdata(swd0), .sram_rdata(srd0),
        .err_oob(err0));

    rvtu_arb_sram_target #(.DEPTH(16), .BASE(32'h1000), .ACK_DLY(3)) u_dut1 (
        .clk(clk), .rst(rst), .dfp_read(rd1), .dfp_write(wr1), .dfp_ack(ack1),
        .dfp_wdata(wd1), .dfp_rdata(rdat1), .dfp_rdata_valid(rv1), .sram_re(re1),
        .sram_we(we1), .sram_idx(idx1), .sram_wdata(swd1), .sram_rdata(srd1),
        .err_oob(err1));

    // SRAM macros: 1-cycle read latency, garbage on the read port when not enabled.
    logic [127:0] mem0 [256];
    logic [127:0] mem1 [16];
    always @(posedge clk) begin
        srd0 <= re0 ? mem0[idx0] : {$urandom, $urandom, $urandom, $urandom};
        srd1 <= re1 ? mem1[idx1] : {$urandom, $urandom, $urandom, $urandom};
        if (we0) mem0[idx0] <= swd0;
        if (we1) mem1[idx1] <= swd1;
    end

    // Reference line contents and expected per-cycle outputs keyed by (cycle, target).
    logic [127:0] ref0 [256];
    logic [127:0] ref1 [16];
    bit           e_ack [longint];
    bit           e_re  [longint];
    bit           e_we  [longint];
    bit           e_val [longint];
    logic [31:0]  e_rd  [longint];
    int           e_idx [longint];
    logic [127:0] e_wd  [longint];
    localparam int BIG = 32'h7fff_ffff;
    int err_cyc [2];

    int total = 0, passed = 0;
    bit cmp_en = 1'b0;

    function automatic longint key(int c, int s);
        return longint'(c) * 2 + longint'(s);
    endfunction

    function automatic logic [127:0] get_ref(int s, int i);
        if (s == 0) return ref0[i];
        return ref1[i];
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int s, bit r, bit w, logic [31:0] d);
        if (s == 0) begin rd0 = r; wr0 = w; wd0 = d; end
        else begin rd1 = r; wr1 = w; wd1 = d; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        err_cyc[0] = BIG;
        err_cyc[1] = BIG;
        set_in(0, 0, 0, 0);
        set_in(1, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    // One full initiator transaction; rst_at >= 0 pulses reset at that offset from ack.
    task automatic txn(int s, bit r, bit w, logic [31:0] addr, logic [127:0] line,
                       int rst_at, output int t_ack);
        int S, T, ix;
        longint a, b, span;
        bit oob;
        logic [127:0] old;
        b    = (s == 0) ? 64'h0 : 64'h1000;
        span = (s == 0) ? 256 * 16 : 16 * 16;
        S = cyc;
        T = S + ((s == 0) ? 0 : 3);
        t_ack = T;
        a   = longint'(addr);
        oob = (a < b) || (a - b >= span);
        ix  = oob ? 0 : int'((a - b) / 16);
        e_ack[key(T, s)] = 1'b1;
        if (oob && T + 2 < err_cyc[s]) err_cyc[s] = T + 2;
        if (r) begin
            if (!oob) begin
                e_re[key(T + 2, s)]  = 1'b1;
                e_idx[key(T + 2, s)] = ix;
            end
            old = oob ? 128'h0 : get_ref(s, ix);
            for (int k = 0; k < 5; k++) e_val[key(T + 3 + k, s)] = 1'b1;
            for (int k = 0; k < 4; k++) e_rd[key(T + 4 + k, s)] = old[32*k +: 32];
        end else if (!oob && rst_at < 0) begin
            e_we[key(T + 6, s)]  = 1'b1;
            e_idx[key(T + 6, s)] = ix;
            e_wd[key(T + 6, s)]  = line;
            if (s == 0) ref0[ix] = line;
            else ref1[ix] = line;
        end
        set_in(s, r, w, $urandom);
        while (cyc < T) tick();
        tick();
        set_in(s, 0, 0, addr);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rst_at == 2 + k) begin
                do_reset();
                return;
            end
            set_in(s, 0, 0, r ? $urandom : line[32*k +: 32]);
        end
        while (cyc < T + (r ? 8 : 7)) tick();
    endtask

    task automatic drop_req(int s);
        set_in(s, 1, 0, 0);
        tick();
        set_in(s, 0, 0, 0);
        tick();
    endtask

    // Per-cycle comparison of both targets against the timeline model.
    always @(negedge clk) begin : cmp
        logic a_ack, a_re, a_we, a_v, a_err;
        logic [31:0] a_rd;
        logic [127:0] a_wd;
        int a_ix;
        longint k;
        if (cmp_en) begin
            for (int s = 0; s < 2; s++) begin
                k = key(cyc, s);
                if (s == 0) begin
                    a_ack = ack0; a_re = re0; a_we = we0; a_v = rv0; a_err = err0;
                    a_rd = rdat0; a_wd = swd0; a_ix = int'(idx0);
                end else begin
                    a_ack = ack1; a_re = re1; a_we = we1; a_v = rv1; a_err = err1;
                    a_rd = rdat1; a_wd = swd1; a_ix = int'(idx1);
                end
                chk($sformatf("ack%0d", s), a_ack, e_ack.exists(k));
                chk($sformatf("sram_re%0d", s), a_re, e_re.exists(k));
                chk($sformatf("sram_we%0d", s), a_we, e_we.exists(k));
                chk($sformatf("rvalid%0d", s), a_v, e_val.exists(k));
                chk($sformatf("rdata%0d", s), a_rd, e_rd.exists(k) ? e_rd[k] : 32'h0);
                chk($sformatf("err_oob%0d", s), a_err, cyc >= err_cyc[s]);
                if (e_re.exists(k) || e_we.exists(k))
                    chk($sformatf("sram_idx%0d", s), a_ix, e_idx[k]);
                if (e_we.exists(k))
                    chk($sformatf("sram_wdata%0d", s), a_wd, e_wd[k]);
            end
        end
    end

    // Observation taps for the literal checks that pin the model.
    int lw_cyc, lw_idx, we_cnt0 = 0, re_cnt0 = 0, ack1_cyc;
    logic [127:0] lw_wd;
    logic [31:0] rq [$];
    always @(negedge clk) begin
        if (we0) begin lw_cyc = cyc; lw_idx = int'(idx0); lw_wd = swd0; we_cnt0++; end
        if (re0) re_cnt0++;
        if (rv0) rq.push_back(rdat0);
        if (ack1) ack1_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, S, n;
        logic [127:0] v;
        logic [31:0] lit [5];
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        set_in(1, 0, 0, 0);
        err_cyc[0] = BIG;
        err_cyc[1] = BIG;
        for (int i = 0; i < 256; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            mem0[i] = v; ref0[i] = v;
        end
        for (int i = 0; i < 16; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            mem1[i] = v; ref1[i] = v;
        end
        repeat (3) tick();
        chk("rst_rdata", rdat0, 32'h0);
        chk("rst_err", err0, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick();

        txn(0, 0, 1, 32'h40, 128'h44444444_33333333_22222222_11111111, -1, t);
        chk("lit_we_cycle", lw_cyc, t + 6);
        chk("lit_we_idx", lw_idx, 4);
        chk("lit_we_line", lw_wd, 128'h44444444_33333333_22222222_11111111);

        lit = '{32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        rq.delete();
        txn(0, 1, 0, 32'h4c, 128'h0, -1, t);
        chk("lit_rd_beats", rq.size(), 5);
        for (int i = 0; i < 5 && i < rq.size(); i++) chk($sformatf("lit_rd_beat%0d", i), rq[i], lit[i]);

        ack1_cyc = -1;
        S = cyc;
        txn(1, 1, 0, 32'h1030, 128'h0, -1, t);
        chk("lit_ack_dly", ack1_cyc, S + 3);
        ack1_cyc = -1;
        drop_req(1);
        chk("lit_drop_noack", ack1_cyc, -1);

        n = re_cnt0;
        rq.delete();
        txn(0, 1, 0, 32'h1000, 128'h0, -1, t);
        chk("lit_oob_no_re", re_cnt0, n);
        chk("lit_oob_beats", rq.size(), 5);
        for (int i = 0; i < 5 && i < rq.size(); i++) chk($sformatf("lit_oob_beat%0d", i), rq[i], 32'h0);
        chk("lit_oob_err", err0, 1'b1);
        n = we_cnt0;
        txn(0, 0, 1, 32'h1000, {4{32'hdeadbeef}}, -1, t);
        chk("lit_oob_no_we", we_cnt0, n);
        chk("lit_oob_sticky", err0, 1'b1);

        txn(0, 0, 1, 32'h80, {4{32'hcafef00d}}, 4, t);
        chk("lit_rst_err_clr", err0, 1'b0);
        chk("lit_rst_no_we", we_cnt0, n);
        rq.delete();
        txn(0, 1, 0, 32'h80, 128'h0, -1, t);
        chk("lit_rst_old_data", (rq.size() > 1) ? rq[1] : 32'hx, ref0[8][31:0]);

        rq.delete();
        txn(0, 1, 1, 32'h40, {4{32'h55555555}}, -1, t);
        chk("lit_both_is_read", rq.size(), 5);
        chk("lit_both_beat3", (rq.size() > 4) ? rq[4] : 32'hx, 32'h44444444);

        repeat (150) begin
            int mode;
            logic [31:0] addr;
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 99) < 85) addr = {20'h0, 8'($urandom_range(0, 255)), 4'($urandom)};
            else addr = $urandom | 32'h0000_1000;
            txn(0, mode != 1, mode != 0, addr, {$urandom, $urandom, $urandom, $urandom}, -1, t);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (40) begin
            int mode;
            mode = $urandom_range(0, 5);
            if (mode == 5) drop_req(1);
            else txn(1, mode < 3, mode >= 2, 32'($urandom_range(32'h0f00, 32'h1140)),
                     {$urandom, $urandom, $urandom, $urandom}, -1, t);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
